mux_scan_reg: RTL and testbench

//  Parametrised N-channel, W-bit registered multiplexer with valid/ready output.

---
 rtl/mux_scan_reg.sv | 156 +++++++++++++++
 tb/tb_mux_scan_reg.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N-channel mux with manual select, masked scan and valid/ready output
module mux_scan_reg #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 8,
   parameter int SEL_W    = 3,
   parameter int DWELL    = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_flat,
   input  logic                      en,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel_in,
   input  logic                      sel_load,
   input  logic [CHANNELS-1:0]       chan_mask,
   output logic [WIDTH-1:0]          out_data,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      sel_err
);

   localparam int              DW_W = $clog2(DWELL) + 1;
   localparam logic [SEL_W:0]  CH_L = (SEL_W+1)'(CHANNELS);
   localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t            state_q;
   logic [SEL_W-1:0]  cur_sel_q, cur_sel_d;
   logic [DW_W-1:0]   dwell_q, dwell_d;
   logic [WIDTH-1:0]  out_data_q;
   logic [SEL_W-1:0]  out_sel_q;
   logic              out_valid_q;
   logic              sel_err_q, sel_err_d;

   logic [WIDTH-1:0]  chan_data [CHANNELS];
   logic [SEL_W-1:0]  low_sel;
   logic [SEL_W-1:0]  next_sel;
   int                idx;
   logic              slot_free;
   logic              mask_any;
   logic              go;
   logic              sel_ok;
   logic              sel_illegal;
   logic              capture;

   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         chan_data[k] = in_flat[k*WIDTH +: WIDTH];
      end
   end

   // lowest enabled channel, and the next enabled one above cur_sel with wrap
   always_comb begin
      low_sel  = '0;
      next_sel = cur_sel_q;
      idx      = 0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         if (chan_mask[k]) begin
            low_sel = SEL_W'(k);
         end
      end
      for (int i = CHANNELS - 1; i >= 1; i--) begin
         idx = (int'(cur_sel_q) + i) % CHANNELS;
         if (chan_mask[idx]) begin
            next_sel = SEL_W'(idx);
         end
      end
   end

   always_comb begin
      slot_free   = !out_valid_q || out_ready;
      mask_any    = |chan_mask;
      go          = en && (!mode || mask_any);
      sel_ok      = {1'b0, sel_in} < CH_L;
      sel_illegal = mode && mask_any && !chan_mask[cur_sel_q];
      capture     = (state_q == S_RUN) && go && slot_free && !sel_illegal;
      sel_err_d   = !mode && sel_load && !sel_ok;
   end

   // manual mode never accumulates dwell, so a return to scan always starts a full dwell
   always_comb begin
      cur_sel_d = cur_sel_q;
      dwell_d   = dwell_q;
      if (!mode) begin
         dwell_d = '0;
         if (sel_load && sel_ok) begin
            cur_sel_d = sel_in;
         end
      end else if (sel_illegal) begin
         cur_sel_d = low_sel;
         dwell_d   = '0;
      end else if (capture) begin
         if (dwell_q == DWELL_LAST) begin
            dwell_d   = '0;
            cur_sel_d = next_sel;
         end else begin
            dwell_d = dwell_q + DW_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cur_sel_q   <= '0;
         dwell_q     <= '0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         sel_err_q   <= 1'b0;
      end else begin
         cur_sel_q <= cur_sel_d;
         dwell_q   <= dwell_d;
         sel_err_q <= sel_err_d;
         case (state_q)
            S_IDLE: begin
               if (slot_free) begin
                  out_valid_q <= 1'b0;
               end
               if (go) begin
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               // a stalled sample stays put even while leaving RUN
               if (!go) begin
                  state_q <= S_IDLE;
                  if (slot_free) begin
                     out_valid_q <= 1'b0;
                  end
               end else if (slot_free) begin
                  if (capture) begin
                     out_data_q  <= chan_data[cur_sel_q];
                     out_sel_q   <= cur_sel_q;
                     out_valid_q <= 1'b1;
                  end else begin
                     out_valid_q <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_sel   = out_sel_q;
   assign out_valid = out_valid_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - randomized and directed bench for mux_scan_reg against a sample-slot model
module tb_mux_scan_reg;
   localparam int W   = 8;
   localparam int CH  = 8;
   localparam int SW  = 3;
   localparam int DW  = 4;
   localparam int CH6 = 6;
   localparam int DW6 = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [CH*W-1:0] in_flat;
   logic            en, mode, sel_load, out_ready;
   logic [SW-1:0]   sel_in;
   logic [CH-1:0]   chan_mask;

   logic [W-1:0]    out_data;
   logic [SW-1:0]   out_sel;
   logic            out_valid, sel_err;
   logic [W-1:0]    out_data6;
   logic [SW-1:0]   out_sel6;
   logic            out_valid6, sel_err6;

   int n_cmp = 0;
   int n_err = 0;

   bit        m_run, m_valid, m_err;
   logic [W-1:0] m_data;
   int        m_sel, m_cur, m_cnt;
   int        obs[$];

   always #5 clk = ~clk;

   mux_scan_reg #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(DW)) dut (
      .clk(clk), .rst_n(rst_n), .in_flat(in_flat), .en(en), .mode(mode),
      .sel_in(sel_in), .sel_load(sel_load), .chan_mask(chan_mask),
      .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
      .out_ready(out_ready), .sel_err(sel_err)
   );

   mux_scan_reg #(.WIDTH(W), .CHANNELS(CH6), .SEL_W(SW), .DWELL(DW6)) dut6 (
      .clk(clk), .rst_n(rst_n), .in_flat(in_flat[CH6*W-1:0]), .en(en), .mode(mode),
      .sel_in(sel_in), .sel_load(sel_load), .chan_mask(chan_mask[CH6-1:0]),
      .out_data(out_data6), .out_sel(out_sel6), .out_valid(out_valid6),
      .out_ready(out_ready), .sel_err(sel_err6)
   );

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int lowest(input logic [CH-1:0] m);
      for (int k = 0; k < CH; k++) if (m[k]) return k;
      return 0;
   endfunction

   function automatic int next_on(input logic [CH-1:0] m, input int c);
      for (int i = 1; i <= CH; i++) if (m[(c + i) % CH]) return (c + i) % CH;
      return c;
   endfunction

   task automatic model_reset();
      m_run = 0; m_valid = 0; m_err = 0; m_data = '0;
      m_sel = 0; m_cur = 0; m_cnt = 0;
   endtask

   // one output slot; a capture fills it, a transfer or idle cycle empties it
   task automatic model_step();
      bit free, any, go, illegal, cap;
      free    = !m_valid || out_ready;
      any     = chan_mask != 0;
      go      = en && (!mode || any);
      illegal = mode && any && !chan_mask[m_cur];
      cap     = m_run && go && free && !illegal;
      m_err   = !mode && sel_load && (int'(sel_in) >= CH);
      if (free) begin
         m_valid = cap;
         if (cap) begin
            m_data = in_flat[m_cur*W +: W];
            m_sel  = m_cur;
         end
      end
      if (!mode) begin
         m_cnt = 0;
         if (sel_load && int'(sel_in) < CH) m_cur = int'(sel_in);
      end else if (illegal) begin
         m_cnt = 0;
         m_cur = lowest(chan_mask);
      end else if (cap) begin
         m_cnt++;
         if (m_cnt == DW) begin
            m_cnt = 0;
            m_cur = next_on(chan_mask, m_cur);
         end
      end
      m_run = go;
   endtask

   task automatic step();
      if (out_valid && out_ready) obs.push_back(int'(out_sel));
      model_step();
      @(posedge clk);
      #1;
      chk_eq("valid", out_valid, m_valid);
      chk_eq("data", out_data, m_data);
      chk_eq("sel", out_sel, m_sel);
      chk_eq("err", sel_err, m_err);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic set_ch(input int k, input logic [W-1:0] v);
      in_flat[k*W +: W] = v;
   endtask

   int pat4[3] = '{0, 2, 7};
   int exp6[8] = '{1, 1, 1, 1, 1, 1, 1, 4};

   initial begin
      rst_n = 1'b0; en = 0; mode = 0; sel_load = 0; out_ready = 0;
      sel_in = '0; chan_mask = '0; in_flat = '0;
      model_reset();
      @(posedge clk);
      #1;
      chk_eq("rst_valid", out_valid, 0);
      chk_eq("rst_data", out_data, 0);
      chk_eq("rst_sel", out_sel, 0);
      chk_eq("rst_err", sel_err, 0);
      rst_n = 1'b1;

      // manual select of channel 5
      for (int k = 0; k < CH; k++) set_ch(k, W'(8'h10 + k));
      set_ch(5, 8'hA5);
      en = 1; mode = 0; out_ready = 1;
      step();
      sel_load = 1; sel_in = 3'd5;
      step();
      sel_load = 0;
      for (int r = 0; r < 3; r++) begin
         step();
         chk_eq("t2_data", out_data, 8'hA5);
         chk_eq("t2_sel", out_sel, 5);
      end

      // asynchronous reset between clock edges
      chk_eq("t1_pre_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk_eq("t1_valid", out_valid, 0);
      chk_eq("t1_data", out_data, 0);
      chk_eq("t1_sel", out_sel, 0);
      chk_eq("t1_err", sel_err, 0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // out-of-range select on the 6-channel instance
      set_ch(3, 8'h3C);
      sel_load = 1; sel_in = 3'd3;
      step();
      sel_load = 0;
      step();
      chk_eq("t3_sel_a", out_sel6, 3);
      chk_eq("t3_data", out_data6, 8'h3C);
      sel_load = 1; sel_in = 3'd7;
      step();
      chk_eq("t3_err_hi", sel_err6, 1);
      chk_eq("t3_sel_b", out_sel6, 3);
      sel_load = 0;
      step();
      chk_eq("t3_err_lo", sel_err6, 0);
      chk_eq("t3_sel_c", out_sel6, 3);
      chk_eq("t3_valid", out_valid6, 1);

      // scan over channels 0,2,7 with a mid-dwell stall
      do_reset();
      mode = 1; chan_mask = 8'b1000_0101; en = 1; out_ready = 1;
      obs.delete();
      for (int s = 0; s < 24; s++) begin
         out_ready = !(s >= 7 && s < 10);
         in_flat = {$urandom, $urandom};
         step();
      end
      chk_eq("t4_count", 64'(obs.size() >= 14), 1);
      for (int k = 0; k < 14 && k < obs.size(); k++) chk_eq("t4_seq", obs[k], pat4[(k / 4) % 3]);

      // mask cleared while stalled
      out_ready = 0;
      step();
      chan_mask = '0;
      step();
      step();
      chk_eq("t5_hold", out_valid, 1);
      out_ready = 1;
      step();
      chk_eq("t5_drop", out_valid, 0);
      step();
      chk_eq("t5_idle", out_valid, 0);

      // leaving scan mid-dwell restarts the dwell on return
      do_reset();
      mode = 1; chan_mask = 8'b0001_0010; en = 1; out_ready = 1;
      obs.delete();
      for (int s = 0; s < 11; s++) begin
         mode = (s != 3);
         step();
      end
      chk_eq("t6_count", 64'(obs.size() >= 8), 1);
      for (int k = 0; k < 8 && k < obs.size(); k++) chk_eq("t6_seq", obs[k], exp6[k]);

      // randomized traffic
      do_reset();
      chan_mask = 8'($urandom);
      for (int s = 0; s < 3000; s++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         sel_load = ($urandom_range(0, 9) == 0);
         sel_in = 3'($urandom);
         if ($urandom_range(0, 29) == 0) chan_mask = ($urandom_range(0, 3) == 0) ? '0 : 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 7);
         in_flat = {$urandom, $urandom};
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
